fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decode stage and its F/D buffer.
- Owns the PC and issues halfword requests to instruction memory (16-bit words, variable-latency ack).
- Assembles 16- or 32-bit instructions into the 32-bit instruction word that decode consumes.
- Holds the result under downstream stall and discards work on branch redirect.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode pipeline definitions: fetch state encoding and the
// halfword / instruction geometry that both stages agree on.
package fetch_unit_pkg;

    // Instruction memory returns 16-bit halfwords; decode consumes 32-bit words.
    localparam int HW_W    = 16;
    localparam int INSTR_W = 32;

    // Bit of the first halfword that flags a 32-bit (immediate-carrying) instruction.
    localparam int IMM_BIT = 15;

    typedef enum logic [1:0] {
        FETCH_LO = 2'd0,   // fetching first (or only) halfword
        FETCH_HI = 2'd1,   // fetching second halfword of a long instruction
        WAIT_OUT = 2'd2,   // instruction complete, waiting for the output slot
        DISCARD  = 2'd3    // redirected with a request in flight; drop its data
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus: halfword request/ack with variable latency.
// The ack may arrive in the same cycle as the request.
interface fetch_unit_if #(
    parameter int PC_W = 32
);
    import fetch_unit_pkg::*;

    logic            im_req;
    logic [PC_W-1:0] im_addr;
    logic [HW_W-1:0] im_rdata;
    logic            im_ack;

    // Fetch unit side
    modport master (
        output im_req,
        output im_addr,
        input  im_rdata,
        input  im_ack
    );

    // Memory side
    modport slave (
        input  im_req,
        input  im_addr,
        output im_rdata,
        output im_ack
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues halfword reads, assembles
// 16/32-bit instructions into a 32-bit word for decode, holds under stall
// and flushes on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              IMM_BIT  = fetch_unit_pkg::IMM_BIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    fetch_unit_if.master       mem,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid
);

    fetch_state_t        state_reg, state_next;
    logic [PC_W-1:0]     pc_reg, pc_next;
    logic [PC_W-1:0]     start_pc_reg, start_pc_next;
    logic [HW_W-1:0]     lo_reg, lo_next;
    logic [INSTR_W-1:0]  stage_instr_reg, stage_instr_next;
    logic [PC_W-1:0]     stage_pc_reg, stage_pc_next;
    logic [PC_W-1:0]     held_addr_reg, held_addr_next;
    logic                pending_reg, pending_next;
    logic [INSTR_W-1:0]  instr_reg, instr_next;
    logic [PC_W-1:0]     instr_pc_reg, instr_pc_next;
    logic                instr_valid_reg, instr_valid_next;

    logic                req;
    logic [PC_W-1:0]     addr;
    logic                fire;
    logic                slot_free;
    logic                complete;
    logic [INSTR_W-1:0]  complete_instr;
    logic [PC_W-1:0]     complete_pc;

    // The output slot can take a new instruction if empty or being consumed now.
    assign slot_free = !instr_valid_reg || !stall;

    // Request generation: a raised request is held (pending/DISCARD) until acked.
    // rst_n gates the request so it drops the instant reset asserts.
    always_comb begin
        req  = 1'b0;
        addr = pc_reg;
        case (state_reg)
            FETCH_LO, FETCH_HI: begin
                req  = pending_reg || slot_free;
                addr = pc_reg;
            end
            DISCARD: begin
                req  = 1'b1;
                addr = held_addr_reg;
            end
            default: begin
                req  = 1'b0;
                addr = pc_reg;
            end
        endcase
        req  = req && rst_n;
        fire = req && mem.im_ack;
    end

    assign mem.im_req  = req;
    assign mem.im_addr = addr;

    // Next-state, instruction assembly, output slot and redirect handling.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        start_pc_next    = start_pc_reg;
        lo_next          = lo_reg;
        stage_instr_next = stage_instr_reg;
        stage_pc_next    = stage_pc_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        complete         = 1'b0;
        complete_instr   = '0;
        complete_pc      = pc_reg;

        pending_next   = req && !mem.im_ack &&
                         (state_reg == FETCH_LO || state_reg == FETCH_HI);
        held_addr_next = (req && !mem.im_ack) ? addr : held_addr_reg;

        // Current output leaves when downstream accepts it.
        if (instr_valid_reg && !stall) begin
            instr_valid_next = 1'b0;
        end

        case (state_reg)
            FETCH_LO: begin
                if (fire) begin
                    pc_next = pc_reg + 1'b1;
                    lo_next = mem.im_rdata;
                    if (mem.im_rdata[IMM_BIT]) begin
                        start_pc_next = pc_reg;
                        state_next    = FETCH_HI;
                    end else begin
                        complete       = 1'b1;
                        complete_instr = {mem.im_rdata, {HW_W{1'b0}}};
                        complete_pc    = pc_reg;
                    end
                end
            end
            FETCH_HI: begin
                if (fire) begin
                    pc_next        = pc_reg + 1'b1;
                    complete       = 1'b1;
                    complete_instr = {lo_reg, mem.im_rdata};
                    complete_pc    = start_pc_reg;
                end
            end
            WAIT_OUT: begin
                if (!stall) begin
                    instr_next       = stage_instr_reg;
                    instr_pc_next    = stage_pc_reg;
                    instr_valid_next = 1'b1;
                    state_next       = FETCH_LO;
                end
            end
            DISCARD: begin
                if (mem.im_ack) begin
                    state_next = FETCH_LO;
                end
            end
            default: state_next = FETCH_LO;
        endcase

        if (complete) begin
            if (slot_free) begin
                instr_next       = complete_instr;
                instr_pc_next    = complete_pc;
                instr_valid_next = 1'b1;
                state_next       = FETCH_LO;
            end else begin
                stage_instr_next = complete_instr;
                stage_pc_next    = complete_pc;
                state_next       = WAIT_OUT;
            end
        end

        // Redirect wins over everything: flush output and any partial/staged work.
        if (redirect) begin
            instr_valid_next = 1'b0;
            pc_next          = redirect_pc;
            pending_next     = 1'b0;
            state_next       = (req && !mem.im_ack) ? DISCARD : FETCH_LO;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FETCH_LO;
            pc_reg          <= RESET_PC;
            start_pc_reg    <= '0;
            lo_reg          <= '0;
            stage_instr_reg <= '0;
            stage_pc_reg    <= '0;
            held_addr_reg   <= '0;
            pending_reg     <= 1'b0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            start_pc_reg    <= start_pc_next;
            lo_reg          <= lo_next;
            stage_instr_reg <= stage_instr_next;
            stage_pc_reg    <= stage_pc_next;
            held_addr_reg   <= held_addr_next;
            pending_reg     <= pending_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
        end
    end

    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory with programmable ack
// latency, request-stability monitor, and an in-order output scoreboard.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;

    fetch_unit_if #(.PC_W(PC_W)) im_bus ();

    fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (32'h10),
        .IMM_BIT  (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem         (im_bus),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [15:0] mem_arr [256];
    int          lat = 1;
    int          wait_cnt = 0;

    always_comb begin
        im_bus.im_ack   = im_bus.im_req && (wait_cnt + 1 >= lat);
        im_bus.im_rdata = mem_arr[im_bus.im_addr[7:0]];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                wait_cnt <= 0;
        else if (im_bus.im_req && !im_bus.im_ack)  wait_cnt <= wait_cnt + 1;
        else                                       wait_cnt <= 0;
    end

    // ---------------- request stability ----------------
    logic            chk_pend = 1'b0;
    logic [PC_W-1:0] pend_addr = '0;

    always @(posedge clk) begin
        chk_pend  <= rst_n && im_bus.im_req && !im_bus.im_ack;
        pend_addr <= im_bus.im_addr;
    end

    always @(negedge clk) begin
        if (rst_n && chk_pend) begin
            check_eq("req_hold", im_bus.im_req, 1'b1);
            check_eq("addr_hold", im_bus.im_addr, pend_addr);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        if (rst_n && mon_en && !redirect && instr_valid && !stall && exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            $display("out pc=%h instr=%h (exp pc=%h instr=%h)", instr_pc, instr, exp_e.pc, exp_e.ins);
            check_eq("instr", instr, exp_e.ins);
            check_eq("instr_pc", instr_pc, exp_e.pc);
        end
    end

    function automatic logic [31:0] dflt(input logic [31:0] a);
        logic [15:0] hw;
        hw = 16'h0100 | {8'h00, a[7:0]};
        return {hw, 16'h0000};
    endfunction

    task automatic push_exp(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.ins = ins;
        e.pc  = pc;
        exp_q.push_back(e);
    endtask

    task automatic start_at(input logic [31:0] pc, input int new_lat);
        @(posedge clk); #1;
        mon_en      = 1'b0;
        exp_q.delete();
        redirect    = 1'b1;
        redirect_pc = pc;
        @(posedge clk); #1;
        redirect    = 1'b0;
        lat         = new_lat;
        mon_en      = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0100 | 16'(i);
        mem_arr[8'h10] = 16'h1234;
        mem_arr[8'h11] = 16'h0042;
        mem_arr[8'h20] = 16'h8001;
        mem_arr[8'h21] = 16'hBEEF;
        mem_arr[8'h60] = 16'h8060;
        mem_arr[8'hFF] = 16'h80FF;
        mem_arr[8'h00] = 16'h0A0A;

        // Reset state
        #12;
        check_eq("rst_im_req", im_bus.im_req, 1'b0);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);

        // Short instructions from RESET_PC, zero-wait memory
        push_exp(32'h12340000, 32'h10);
        push_exp(32'h00420000, 32'h11);
        push_exp(dflt(32'h12), 32'h12);
        push_exp(dflt(32'h13), 32'h13);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("t1_req0", im_bus.im_req, 1'b1);
        check_eq("t1_addr0", im_bus.im_addr, 32'h10);
        check_eq("t1_valid0", instr_valid, 1'b0);
        @(negedge clk);
        check_eq("t1_addr1", im_bus.im_addr, 32'h11);
        check_eq("t1_valid1", instr_valid, 1'b1);
        @(negedge clk);
        check_eq("t1_valid2", instr_valid, 1'b1);
        check_eq("t1_addr2", im_bus.im_addr, 32'h12);
        drain("t1_drain", 20);

        // Long instruction
        start_at(32'h20, 1);
        push_exp(32'h8001BEEF, 32'h20);
        push_exp(dflt(32'h22), 32'h22);
        push_exp(dflt(32'h23), 32'h23);
        @(negedge clk);
        check_eq("t2_addr0", im_bus.im_addr, 32'h20);
        check_eq("t2_valid0", instr_valid, 1'b0);
        @(negedge clk);
        check_eq("t2_addr1", im_bus.im_addr, 32'h21);
        check_eq("t2_valid1", instr_valid, 1'b0);
        @(negedge clk);
        check_eq("t2_valid2", instr_valid, 1'b1);
        check_eq("t2_pc2", instr_pc, 32'h20);
        check_eq("t2_addr2", im_bus.im_addr, 32'h22);
        drain("t2_drain", 20);

        // 3-cycle ack latency
        start_at(32'h30, 3);
        push_exp(dflt(32'h30), 32'h30);
        push_exp(dflt(32'h31), 32'h31);
        push_exp(dflt(32'h32), 32'h32);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t3_wait_valid", instr_valid, 1'b0);
            check_eq("t3_wait_addr", im_bus.im_addr, 32'h30);
        end
        @(negedge clk);
        check_eq("t3_first_valid", instr_valid, 1'b1);
        check_eq("t3_first_pc", instr_pc, 32'h30);
        drain("t3_drain", 40);

        // Downstream stall for 4 cycles
        start_at(32'h50, 1);
        for (int a = 32'h50; a < 32'h58; a++) push_exp(dflt(a), a);
        n = 0;
        while (!(instr_valid && instr_pc == 32'h52) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t4_reach", {31'h0, instr_valid && instr_pc == 32'h52}, 32'h1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t4_hold_pc", instr_pc, 32'h52);
            check_eq("t4_hold_instr", instr, dflt(32'h52));
            check_eq("t4_hold_valid", instr_valid, 1'b1);
            check_eq("t4_no_req", im_bus.im_req, 1'b0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        drain("t4_drain", 30);

        // Long instruction straddling PC wrap
        start_at(32'hFFFF_FFFF, 1);
        push_exp(32'h80FF0A0A, 32'hFFFF_FFFF);
        push_exp(dflt(32'h01), 32'h01);
        push_exp(dflt(32'h02), 32'h02);
        @(negedge clk);
        check_eq("t5_addr_lo", im_bus.im_addr, 32'hFFFF_FFFF);
        @(negedge clk);
        check_eq("t5_addr_hi", im_bus.im_addr, 32'h0);
        drain("t5_drain", 20);

        // Redirect while a request is outstanding
        start_at(32'h10, 3);
        push_exp(32'h12340000, 32'h10);
        push_exp(32'h00420000, 32'h11);
        push_exp(dflt(32'h12), 32'h12);
        push_exp(dflt(32'h40), 32'h40);
        push_exp(dflt(32'h41), 32'h41);
        n = 0;
        while (!(im_bus.im_req && im_bus.im_addr == 32'h13) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t6_reach", {31'h0, im_bus.im_req && im_bus.im_addr == 32'h13}, 32'h1);
        @(posedge clk); #1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        @(posedge clk); #1;
        redirect    = 1'b0;
        @(negedge clk);
        check_eq("t6_valid_drop", instr_valid, 1'b0);
        check_eq("t6_discard_addr", im_bus.im_addr, 32'h13);
        n = 0;
        while (im_bus.im_addr == 32'h13 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_next_addr", im_bus.im_addr, 32'h40);
        drain("t6_drain", 40);

        // Asynchronous reset in the middle of a long fetch
        start_at(32'h60, 3);
        n = 0;
        while (!(im_bus.im_req && im_bus.im_addr == 32'h61) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t7_reach_hi", {31'h0, im_bus.im_req && im_bus.im_addr == 32'h61}, 32'h1);
        #2;
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_eq("t7_req_drop", im_bus.im_req, 1'b0);
        check_eq("t7_valid_drop", instr_valid, 1'b0);
        check_eq("t7_pc_clear", instr_pc, 32'h0);
        lat = 1;
        push_exp(32'h12340000, 32'h10);
        push_exp(32'h00420000, 32'h11);
        push_exp(dflt(32'h12), 32'h12);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("t7_restart_addr", im_bus.im_addr, 32'h10);
        check_eq("t7_restart_req", im_bus.im_req, 1'b1);
        drain("t7_drain", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
